// File: rtl/sram_port_initiator_if.sv
// Request, response and macro-port signals of the SRAM port initiator.
// The slave view is the initiator itself; the master view drives it.
interface sram_port_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_WMASKS = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  mem_csb0;
    logic                  mem_web0;
    logic [NUM_WMASKS-1:0] mem_wmask0;
    logic [ADDR_WIDTH-1:0] mem_addr0;
    logic [DATA_WIDTH-1:0] mem_din0;
    logic [DATA_WIDTH-1:0] mem_dout0;

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  rsp_ready, mem_dout0,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_csb0, mem_web0, mem_wmask0, mem_addr0, mem_din0
    );

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        output rsp_ready, mem_dout0,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_csb0, mem_web0, mem_wmask0, mem_addr0, mem_din0
    );
endinterface

// File: rtl/sram_port_initiator.sv
// Initiator for the 1RW OpenRAM port: issues requests straight to the macro
// and returns read data in order through a bypass plus 2-entry skid FIFO.
module sram_port_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_WMASKS = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    sram_port_initiator_if.slave bus
);
    logic [1:0]            cnt;
    logic [1:0]            cnt_nx;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [2:0]            credit;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_en;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Credit counts both buffered and in-flight reads, so dout0 always has a slot.
    assign credit        = {1'b0, cnt} + {2'b00, inflight};
    assign bus.req_ready = (credit < 3'd2);

    assign accept = bus.req_valid && bus.req_ready;
    assign rd_acc = accept && !bus.req_we;
    assign wr_en  = bus.req_we && reset_n;

    assign bus.mem_csb0   = !(accept && reset_n);
    assign bus.mem_web0   = !wr_en;
    assign bus.mem_wmask0 = wr_en ? bus.req_wmask : '0;
    assign bus.mem_addr0  = bus.req_addr;
    assign bus.mem_din0   = bus.req_wdata;

    assign empty         = (cnt == 2'd0);
    assign bus.rsp_valid = !empty || inflight;
    assign bus.rsp_rdata = empty ? bus.mem_dout0 : fifo_q[rd_ptr];

    // dout0 is only held until the next edge, so it is captured unless bypassed.
    assign pop  = !empty && bus.rsp_ready;
    assign push = inflight && !(empty && bus.rsp_ready);

    always_comb begin
        cnt_nx = cnt;
        unique case ({push, pop})
            2'b10:   cnt_nx = cnt + 2'd1;
            2'b01:   cnt_nx = cnt - 2'd1;
            default: cnt_nx = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            inflight <= 1'b0;
        end else begin
            cnt      <= cnt_nx;
            inflight <= rd_acc;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= bus.mem_dout0;
    end
endmodule

// File: tb/tb_sram_port_initiator.sv
// Directed bench for sram_port_initiator with a behavioural 1RW macro model.
module tb_sram_port_initiator;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    sram_port_initiator_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)
    ) bus ();

    sram_port_initiator #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Macro model: dout0 holds read data for one cycle, garbage otherwise.
    logic [DW-1:0] sram [2**AW];

    always @(posedge clk) begin
        if (!bus.mem_csb0 && bus.mem_web0) begin
            bus.mem_dout0 <= sram[bus.mem_addr0];
        end else begin
            bus.mem_dout0 <= $urandom;
        end
        if (!bus.mem_csb0 && !bus.mem_web0) begin
            for (int b = 0; b < NW; b++) begin
                if (bus.mem_wmask0[b])
                    sram[bus.mem_addr0][8*b +: 8] <= bus.mem_din0[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [NW-1:0] m);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NW-1:0] m);
        drive(1'b1, 1'b1, a, d, m);
        #1;
        chk("wr_ready", bus.req_ready, 1);
        chk("wr_csb", bus.mem_csb0, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive(1'b1, 1'b0, a, '0, '0);
        #1;
        chk("rd_ready", bus.req_ready, 1);
        chk("rd_early_valid", bus.rsp_valid, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("rd_valid", bus.rsp_valid, 1);
        chk("rd_data", bus.rsp_rdata, exp);
        @(negedge clk);
        #1;
        chk("rd_done", bus.rsp_valid, 0);
    endtask

    logic [AW-1:0] alist [8];

    initial begin
        alist = '{11'h000, 11'h200, 11'h400, 11'h600,
                  11'h001, 11'h002, 11'h003, 11'h004};
        reset_n       = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 11'h005, 32'h0, 4'hF);

        // Reset state, including forced macro idle with a request pending
        @(negedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_csb", bus.mem_csb0, 1);
        chk("rst_web", bus.mem_web0, 1);
        chk("rst_wmask", bus.mem_wmask0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.req_valid = 1'b0;
        #1;

        // 1: write then read back with one-cycle latency
        do_write(11'h005, 32'hDEADBEEF, 4'b1111);
        do_read(11'h005, 32'hDEADBEEF);

        // 2: byte-masked overwrite in bank 3
        do_write(11'h7FF, 32'h11223344, 4'b1111);
        drive(1'b1, 1'b1, 11'h7FF, 32'hAABBCCDD, 4'b0101);
        #1;
        chk("mask_wmask", bus.mem_wmask0, 4'b0101);
        chk("mask_web", bus.mem_web0, 0);
        chk("mask_csb", bus.mem_csb0, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        do_read(11'h7FF, 32'h11BB33DD);

        // 3: back-to-back reads across banks, all through bypass
        for (int k = 0; k < 8; k++) do_write(alist[k], 32'h100 + k, 4'hF);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, alist[i], '0, '0);
            #1;
            chk("b2b_ready", bus.req_ready, 1);
            if (i > 0) begin
                chk("b2b_valid", bus.rsp_valid, 1);
                chk("b2b_data", bus.rsp_rdata, 32'h100 + i - 1);
            end
            chk("b2b_fifo_idle", dut.cnt, 0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        #1;
        chk("b2b_last_valid", bus.rsp_valid, 1);
        chk("b2b_last_data", bus.rsp_rdata, 32'h107);
        @(negedge clk);
        #1;
        chk("b2b_idle", bus.rsp_valid, 0);

        // 4: backpressure with continuous reads @1,@2,@3
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 11'h001, '0, '0);
        #1;
        chk("bp_ready0", bus.req_ready, 1);
        @(negedge clk);
        drive(1'b1, 1'b0, 11'h002, '0, '0);
        #1;
        chk("bp_ready1", bus.req_ready, 1);
        chk("bp_data1", bus.rsp_rdata, 32'h104);
        @(negedge clk);
        drive(1'b1, 1'b0, 11'h003, '0, '0);
        #1;
        chk("bp_stall_ready", bus.req_ready, 0);
        chk("bp_stall_csb", bus.mem_csb0, 1);
        chk("bp_stall_data", bus.rsp_rdata, 32'h104);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_full_ready", bus.req_ready, 0);
        chk("bp_full_valid", bus.rsp_valid, 1);
        chk("bp_pop1", bus.rsp_rdata, 32'h104);
        @(negedge clk);
        #1;
        chk("bp_pop2", bus.rsp_rdata, 32'h105);
        chk("bp_ready_again", bus.req_ready, 1);
        chk("bp_issue3", bus.mem_csb0, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("bp_valid3", bus.rsp_valid, 1);
        chk("bp_data3", bus.rsp_rdata, 32'h106);
        @(negedge clk);
        #1;
        chk("bp_idle", bus.rsp_valid, 0);

        // 5: write held off by full FIFO until a pop frees credit
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 11'h005, '0, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 11'h7FF, '0, '0);
        #1;
        chk("wf_head", bus.rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        drive(1'b1, 1'b1, 11'h005, 32'h12345678, 4'hF);
        #1;
        chk("wf_ready_a", bus.req_ready, 0);
        chk("wf_csb_a", bus.mem_csb0, 1);
        @(negedge clk);
        #1;
        chk("wf_ready_b", bus.req_ready, 0);
        chk("wf_csb_b", bus.mem_csb0, 1);
        chk("wf_hold", bus.rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("wf_ready_c", bus.req_ready, 0);
        chk("wf_csb_c", bus.mem_csb0, 1);
        @(negedge clk);
        #1;
        chk("wf_ready_d", bus.req_ready, 1);
        chk("wf_csb_d", bus.mem_csb0, 0);
        chk("wf_web_d", bus.mem_web0, 0);
        chk("wf_data2", bus.rsp_rdata, 32'h11BB33DD);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("wf_drained", bus.rsp_valid, 0);
        do_read(11'h005, 32'h12345678);

        // 6: reset with two reads buffered discards them
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 11'h001, '0, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 11'h002, '0, '0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rs_count", dut.cnt, 2);
        drive(1'b1, 1'b0, 11'h003, '0, '0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rs_valid", bus.rsp_valid, 0);
        chk("rs_ready", bus.req_ready, 1);
        chk("rs_csb", bus.mem_csb0, 1);
        @(negedge clk);
        reset_n = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("rs_no_stale0", bus.rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("rs_no_stale1", bus.rsp_valid, 0);
        do_read(11'h200, 32'h101);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
